// File: rtl/fixed_point_pkg.sv
// Shared Q-format types, limits and the round/shift/saturate helper used by the
// DSP arithmetic blocks.
package fixed_point_pkg;

    localparam int PKG_DATA_WIDTH = 32;
    localparam int MAX_DW         = 64;
    localparam int EXT_W          = 2 * MAX_DW;

    typedef logic signed [PKG_DATA_WIDTH-1:0] sample_t;
    typedef logic signed [EXT_W-1:0]          wide_t;

    localparam sample_t MAX_POS = {1'b0, {(PKG_DATA_WIDTH-1){1'b1}}};
    localparam sample_t MAX_NEG = {1'b1, {(PKG_DATA_WIDTH-1){1'b0}}};

    // Works on a sign-extended wide value so any DATA_WIDTH up to MAX_DW shares it;
    // returns {overflow, value} with the result in the low dw bits of value.
    function automatic logic [MAX_DW:0] round_shift_sat(
        input wide_t full,
        input int    dw,
        input int    frac,
        input int    round_en,
        input int    sat_en
    );
        wide_t             biased;
        wide_t             s;
        wide_t             lim_pos;
        wide_t             lim_neg;
        logic [MAX_DW-1:0] val;
        logic              ovf;
        biased = full;
        if (round_en != 0 && frac > 0) begin
            biased = full + (wide_t'(1) <<< (frac - 1));
        end
        s       = biased >>> frac;
        lim_pos = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        lim_neg = -(wide_t'(1) <<< (dw - 1));
        val     = s[MAX_DW-1:0];
        ovf     = 1'b0;
        if (s > lim_pos) begin
            ovf = 1'b1;
            if (sat_en != 0) val = lim_pos[MAX_DW-1:0];
        end else if (s < lim_neg) begin
            ovf = 1'b1;
            if (sat_en != 0) val = lim_neg[MAX_DW-1:0];
        end
        return {ovf, val};
    endfunction

endpackage

// File: rtl/fixed_point_scale.sv
// Combinational round, arithmetic shift and saturate/wrap of a double-width
// product down to a DATA_WIDTH Q-format sample.
module fixed_point_scale
    import fixed_point_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int ROUND      = 1,
    parameter int SATURATE   = 1
) (
    input  logic signed [2*DATA_WIDTH-1:0] i_full,
    output logic signed [DATA_WIDTH-1:0]   o_value,
    output logic                           o_overflow
);

    logic [MAX_DW:0] w_res;

    assign w_res      = round_shift_sat(wide_t'(i_full), DATA_WIDTH, FRAC_BITS, ROUND, SATURATE);
    assign o_value    = w_res[DATA_WIDTH-1:0];
    assign o_overflow = w_res[MAX_DW];

    generate
        if (DATA_WIDTH < MAX_DW) begin : g_unused
            logic w_unused_hi;
            assign w_unused_hi = ^w_res[MAX_DW-1:DATA_WIDTH];
        end
    endgenerate

endmodule

// File: rtl/fixed_point_multiplier.sv
// Pipelined signed fixed-point multiplier with valid/ready on both sides.
// Multiply in the first stage, scaling in the last, pure delay in between.
module fixed_point_multiplier
    import fixed_point_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int STAGES     = 3,
    parameter int ROUND      = 1,
    parameter int SATURATE   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] multiplicand,
    input  logic signed [DATA_WIDTH-1:0] multiplier,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] product,
    output logic                         overflow,
    output logic                         busy
);

    localparam int PW = 2 * DATA_WIDTH;

    // Handshake: a transfer happens on any cycle with in_valid && in_ready;
    // the output slot is consumed on out_valid && out_ready. One global
    // advance moves every stage together, so a stall freezes the whole pipe.
    logic                 w_advance;
    logic signed [PW-1:0] w_mult;
    logic [STAGES-1:0]    w_vin;
    logic signed [PW-1:0] w_fin [STAGES];
    logic [STAGES-1:0]    w_valid;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_mult    = PW'(multiplicand) * PW'(multiplier);
    assign w_vin[0]  = in_valid;
    assign w_fin[0]  = w_mult;
    assign busy      = |w_valid;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k < STAGES - 1) begin : g_delay
                logic                 r_valid;
                logic signed [PW-1:0] r_full;

                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        r_valid <= 1'b0;
                        r_full  <= '0;
                    end else if (w_advance) begin
                        r_valid <= w_vin[k];
                        if (w_vin[k]) r_full <= w_fin[k];
                    end
                end

                assign w_vin[k+1] = r_valid;
                assign w_fin[k+1] = r_full;
                assign w_valid[k] = r_valid;
            end else begin : g_out
                logic signed [DATA_WIDTH-1:0] w_scaled;
                logic                         w_ovf;
                logic                         r_valid;
                logic                         r_overflow;
                logic signed [DATA_WIDTH-1:0] r_product;

                fixed_point_scale #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .FRAC_BITS  (FRAC_BITS),
                    .ROUND      (ROUND),
                    .SATURATE   (SATURATE)
                ) u_scale (
                    .i_full     (w_fin[k]),
                    .o_value    (w_scaled),
                    .o_overflow (w_ovf)
                );

                // Result registers only load with a real item, so they hold across bubbles.
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        r_valid    <= 1'b0;
                        r_product  <= '0;
                        r_overflow <= 1'b0;
                    end else if (w_advance) begin
                        r_valid <= w_vin[k];
                        if (w_vin[k]) begin
                            r_product  <= w_scaled;
                            r_overflow <= w_ovf;
                        end
                    end
                end

                assign w_valid[k] = r_valid;
                assign out_valid  = r_valid;
                assign product    = r_product;
                assign overflow   = r_overflow;
            end
        end
    endgenerate

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Bench for fixed_point_multiplier: default instance (round + saturate) and a
// truncate + wrap instance fed the same stream, each with its own scoreboard.
module tb_fixed_point_multiplier;

    localparam int DW     = 32;
    localparam int FRAC   = 10;
    localparam int STAGES = 3;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;

    logic          in_ready,  out_valid,   overflow,   busy;
    logic [DW-1:0] product;
    logic          in_ready_b, out_valid_b, overflow_b, busy_b;
    logic [DW-1:0] product_b;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_out    = 0;

    logic [DW:0] exp_q[$];
    logic [DW:0] exp_b_q[$];

    fixed_point_multiplier #(
        .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .STAGES(STAGES), .ROUND(1), .SATURATE(1)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(a_in), .multiplier(b_in), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .overflow(overflow), .busy(busy)
    );

    fixed_point_multiplier #(
        .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .STAGES(STAGES), .ROUND(0), .SATURATE(0)
    ) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .multiplicand(a_in), .multiplier(b_in), .out_valid(out_valid_b),
        .out_ready(out_ready), .product(product_b), .overflow(overflow_b), .busy(busy_b)
    );

    // ---------------- clock / watchdog ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [DW:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input bit rnd, input bit sat);
        logic signed [2*DW-1:0] full;
        logic signed [2*DW-1:0] s;
        full = $signed(a) * $signed(b);
        if (rnd) full = full + (64'sd1 <<< (FRAC - 1));
        s = full >>> FRAC;
        if (s > 64'sh7FFFFFFF)       return {1'b1, sat ? 32'h7FFFFFFF : s[DW-1:0]};
        if (s < -(64'sh80000000))    return {1'b1, sat ? 32'h80000000 : s[DW-1:0]};
        return {1'b0, s[DW-1:0]};
    endfunction

    function automatic logic in_at(input int e);
        logic [3:0] pat;
        pat = 4'b0101;
        if (e < 0 || e > 3) return 1'b0;
        return pat[e];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            cyc();
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || busy_b) && n < 50) begin
            cyc();
            n++;
        end
        check("drain_idle", {busy, busy_b}, 2'b00);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clock) begin
        if (!reset) begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            check("in_ready_b", in_ready_b, in_ready);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a_in, b_in, 1'b1, 1'b1));
                n_acc++;
            end
            if (in_valid && in_ready_b) exp_b_q.push_back(model(a_in, b_in, 1'b0, 1'b0));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $error("FAIL spurious_out: observed=%0h expected=none", product);
                end else begin
                    check("sb_product", {overflow, product}, exp_q.pop_front());
                end
            end
            if (out_valid_b && out_ready) begin
                if (exp_b_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $error("FAIL spurious_out_b: observed=%0h expected=none", product_b);
                end else begin
                    check("sb_product_b", {overflow_b, product_b}, exp_b_q.pop_front());
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    logic [DW-1:0] ta [8] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF,
                              32'h80000000, 32'h80000000, 32'd3072, 32'd3072};
    logic [DW-1:0] tb [8] = '{32'd512, 32'd512, 32'd513, 32'h7FFFFFFF,
                              32'h7FFFFFFF, 32'h80000000, 32'hFFFFF800, 32'd2048};
    logic [DW:0]   te [8] = '{{1'b0, 32'h1}, {1'b0, 32'h0}, {1'b0, 32'hFFFFFFFF},
                              {1'b1, 32'h7FFFFFFF}, {1'b1, 32'h80000000}, {1'b1, 32'h7FFFFFFF},
                              {1'b0, 32'hFFFFE800}, {1'b0, 32'd6144}};
    logic [DW:0]   te_b [8] = '{{1'b0, 32'h0}, {1'b0, 32'hFFFFFFFF}, {1'b0, 32'hFFFFFFFF},
                                {1'b1, 32'hFFC00000}, {1'b1, 32'h00200000}, {1'b1, 32'h0},
                                {1'b0, 32'hFFFFE800}, {1'b0, 32'd6144}};

    initial begin
        int lat;
        int idx;
        int cyc_n;
        int stalls;
        int acc0;
        int out0;
        int sent;
        logic exp_busy;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_product", product, 32'h0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        cyc();

        // basic scaling and latency: 3.0 * 2.0
        send(32'd3072, 32'd2048);
        wait_out(lat);
        check("basic_latency", lat, STAGES);
        check("basic_product", {overflow, product}, {1'b0, 32'd6144});
        drain();
        repeat (3) cyc();
        check("hold_product", {out_valid, overflow, product}, {1'b0, 1'b0, 32'd6144});

        // rounding / saturation table, one item at a time on both instances
        for (int i = 0; i < 8; i++) begin
            send(ta[i], tb[i]);
            wait_out(lat);
            check("table_latency", lat, STAGES);
            check($sformatf("table_%0d", i), {overflow, product}, te[i]);
            check($sformatf("table_b_%0d", i), {overflow_b, product_b}, te_b[i]);
        end
        drain();

        // back-to-back with backpressure on cycles 4..8
        idx    = 1;
        cyc_n  = 0;
        stalls = 0;
        acc0   = n_acc;
        out0   = n_out;
        while ((idx <= 8 || busy) && cyc_n < 60) begin
            cyc_n++;
            out_ready = !(cyc_n >= 4 && cyc_n <= 8);
            in_valid  = (idx <= 8);
            a_in      = DW'(idx);
            b_in      = DW'(idx + 1);
            @(negedge clock);
            if (!in_ready) stalls++;
            if (in_valid && in_ready) idx++;
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("bp_stall_cycles", stalls, 5);
        check("bp_accepted", n_acc - acc0, 8);
        check("bp_delivered", n_out - out0, 8);

        // bubbles: 1,0,1,0 must reappear STAGES cycles later
        for (int j = 0; j < 7; j++) begin
            in_valid = in_at(j);
            a_in     = DW'((j + 1) * 4096);
            b_in     = 32'd1024;
            cyc();
            exp_busy = 1'b0;
            for (int s = 0; s < STAGES; s++) exp_busy = exp_busy | in_at(j - s);
            check($sformatf("bubble_valid_%0d", j), out_valid, in_at(j - (STAGES - 1)));
            check($sformatf("bubble_busy_%0d", j), busy, exp_busy);
        end
        in_valid = 1'b0;
        drain();

        // reset with three items in flight
        for (int i = 0; i < 3; i++) begin
            a_in     = DW'((i + 5) * 2048);
            b_in     = 32'd3000;
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_product", {overflow, product}, 33'h0);
        check("mid_rst_product_b", {overflow_b, product_b}, 33'h0);
        exp_q.delete();
        exp_b_q.delete();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("no_stale", {out_valid, out_valid_b}, 2'b00);
        end
        send(32'd2560, 32'd4096);
        wait_out(lat);
        check("post_rst_latency", lat, STAGES);
        check("post_rst_product", {overflow, product}, {1'b0, 32'd10240});
        drain();

        // random stream with random backpressure
        sent  = 0;
        cyc_n = 0;
        while (sent < 40 && cyc_n < 400) begin
            cyc_n++;
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(9, 0) < 7);
            a_in      = ($urandom_range(1, 0) == 1) ? $urandom : DW'(int'($urandom_range(200000, 0)) - 100000);
            b_in      = ($urandom_range(1, 0) == 1) ? $urandom : DW'(int'($urandom_range(200000, 0)) - 100000);
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("rand_sent", sent, 40);
        check("sb_empty", exp_q.size(), 0);
        check("sb_b_empty", exp_b_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
